// File: rtl/nv_nvdla_csb_req_sched.sv
// Single-outstanding CSB request scheduler: decodes the client from addr[15:12], issues the
// request, then routes back read data or write completion. NVDLA_CSB_SCHED_TIMEOUT_EN adds a watchdog.
module nv_nvdla_csb_req_sched #(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        csb2nvdla_valid,
  output logic                        csb2nvdla_ready,
  input  logic [15:0]                 csb2nvdla_addr,
  input  logic [31:0]                 csb2nvdla_wdat,
  input  logic                        csb2nvdla_write,
  input  logic                        csb2nvdla_nposted,
  output logic                        nvdla2csb_valid,
  output logic [31:0]                 nvdla2csb_data,
  output logic                        nvdla2csb_wr_complete,
  output logic [NUM_CLIENTS-1:0]      req_pvld,
  input  logic [NUM_CLIENTS-1:0]      req_prdy,
  output logic [62:0]                 req_pd,
  input  logic [NUM_CLIENTS-1:0]      resp_valid,
  input  logic [34*NUM_CLIENTS-1:0]   resp_pd,
  output logic                        sched_timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [4:0] NumClients = 5'(NUM_CLIENTS);

  state_e                  state_q, state_d;
  logic [NUM_CLIENTS-1:0]  sel_q, sel_d;
  logic [NUM_CLIENTS-1:0]  req_pvld_q, req_pvld_d;
  logic [62:0]             req_pd_q, req_pd_d;
  logic                    write_q, write_d;
  logic                    nposted_q, nposted_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    wr_cpl_q, wr_cpl_d;
  logic [31:0]             data_q, data_d;

  logic [3:0]              addr_idx;
  logic                    addr_mapped;
  logic [NUM_CLIENTS-1:0]  addr_onehot;
  logic                    accept;
  logic                    req_hs;
  logic                    resp_sel_valid;
  logic [33:0]             resp_sel_pd;
  logic                    resp_match;
  logic                    expire;
  logic                    unused_resp_err;

  assign addr_idx    = csb2nvdla_addr[15:12];
  assign addr_mapped = ({1'b0, addr_idx} < NumClients);
  assign accept      = csb2nvdla_valid && (state_q == StIdle);
  assign req_hs      = (state_q == StReq) && |(sel_q & req_prdy);

  always_comb begin
    addr_onehot = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      addr_onehot[i] = (addr_idx == 4'(i));
    end
  end

  // Only the selected client's response is visible; others are ignored.
  always_comb begin
    resp_sel_pd = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (sel_q[i]) begin
        resp_sel_pd = resp_sel_pd | resp_pd[34*i +: 34];
      end
    end
  end

  assign resp_sel_valid  = |(sel_q & resp_valid);
  assign resp_match      = (state_q == StWait) && resp_sel_valid && (resp_sel_pd[33] == write_q);
  assign unused_resp_err = resp_sel_pd[32];

`ifdef NVDLA_CSB_SCHED_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  // A matching response in the expiry cycle takes priority over the timeout.
  assign expire = (state_q == StWait) && !resp_match && (cnt_q == TimeoutLast);

  always_comb begin
    cnt_d = cnt_q;
    if (req_hs) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 16'd1;
    end
    timeout_d = timeout_q | expire;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign sched_timeout = timeout_q;
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
  assign expire        = 1'b0;
  assign sched_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = addr_mapped ? StReq : StDone;
      end
      StReq: begin
        if (req_hs) state_d = (write_q && !nposted_q) ? StIdle : StWait;
      end
      StWait: begin
        if (resp_match || expire) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output/datapath next-state; completion pulses are registered on entry to StDone.
  always_comb begin
    sel_d      = sel_q;
    req_pvld_d = req_pvld_q;
    req_pd_d   = req_pd_q;
    write_d    = write_q;
    nposted_d  = nposted_q;
    data_d     = data_q;
    rd_vld_d   = 1'b0;
    wr_cpl_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          sel_d      = addr_onehot;
          req_pvld_d = addr_onehot;
          req_pd_d   = {7'b0, csb2nvdla_nposted, csb2nvdla_write, csb2nvdla_wdat,
                        6'b0, csb2nvdla_addr};
          write_d    = csb2nvdla_write;
          nposted_d  = csb2nvdla_nposted;
          if (!addr_mapped) begin
            rd_vld_d = !csb2nvdla_write;
            wr_cpl_d = csb2nvdla_write && csb2nvdla_nposted;
            if (!csb2nvdla_write) data_d = '0;
          end
        end
      end
      StReq: begin
        if (req_hs) req_pvld_d = '0;
      end
      StWait: begin
        if (resp_match || expire) begin
          rd_vld_d = !write_q;
          wr_cpl_d = write_q;
          if (!write_q) data_d = resp_match ? resp_sel_pd[31:0] : 32'hFFFF_FFFF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sel_q      <= '0;
      req_pvld_q <= '0;
      req_pd_q   <= '0;
      write_q    <= 1'b0;
      nposted_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      wr_cpl_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      sel_q      <= sel_d;
      req_pvld_q <= req_pvld_d;
      req_pd_q   <= req_pd_d;
      write_q    <= write_d;
      nposted_q  <= nposted_d;
      rd_vld_q   <= rd_vld_d;
      wr_cpl_q   <= wr_cpl_d;
      data_q     <= data_d;
    end
  end

  assign csb2nvdla_ready       = (state_q == StIdle);
  assign req_pvld              = req_pvld_q;
  assign req_pd                = req_pd_q;
  assign nvdla2csb_valid       = rd_vld_q;
  assign nvdla2csb_wr_complete = wr_cpl_q;
  assign nvdla2csb_data        = data_q;

endmodule

// File: tb/tb_nv_nvdla_csb_req_sched.sv
// Directed bench for nv_nvdla_csb_req_sched; expected completions are queued at stimulus time
// and popped when the DUT pulses. Timeout case runs only with NVDLA_CSB_SCHED_TIMEOUT_EN.
module tb_nv_nvdla_csb_req_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          csb_valid = 1'b0;
  logic          csb_ready;
  logic [15:0]   csb_addr = '0;
  logic [31:0]   csb_wdat = '0;
  logic          csb_write = 1'b0;
  logic          csb_nposted = 1'b0;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          wr_cpl;
  logic [N-1:0]  req_pvld;
  logic [N-1:0]  req_prdy = '0;
  logic [62:0]   req_pd;
  logic [N-1:0]  resp_valid = '0;
  logic [34*N-1:0] resp_pd = '0;
  logic          sched_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  nv_nvdla_csb_req_sched #(
    .NUM_CLIENTS   (N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rstn      (rstn),
    .csb2nvdla_valid      (csb_valid),
    .csb2nvdla_ready      (csb_ready),
    .csb2nvdla_addr       (csb_addr),
    .csb2nvdla_wdat       (csb_wdat),
    .csb2nvdla_write      (csb_write),
    .csb2nvdla_nposted    (csb_nposted),
    .nvdla2csb_valid      (rd_valid),
    .nvdla2csb_data       (rd_data),
    .nvdla2csb_wr_complete(wr_cpl),
    .req_pvld             (req_pvld),
    .req_prdy             (req_prdy),
    .req_pd               (req_pd),
    .resp_valid           (resp_valid),
    .resp_pd              (resp_pd),
    .sched_timeout        (sched_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [62:0] mk_pd(input logic [15:0] a, input logic [31:0] d,
                                        input logic w, input logic np);
    return {7'b0, np, w, d, 6'b0, a};
  endfunction

  task automatic host_req(input logic [15:0] a, input logic [31:0] d, input logic w,
                          input logic np);
    csb_addr    = a;
    csb_wdat    = d;
    csb_write   = w;
    csb_nposted = np;
    csb_valid   = 1'b1;
  endtask

  task automatic set_resp(input int c, input logic typ, input logic err, input logic [31:0] d);
    resp_valid = '0;
    resp_pd    = '0;
    resp_valid[c] = 1'b1;
    resp_pd[34*c +: 34] = {typ, err, d};
  endtask

  task automatic clr_resp();
    resp_valid = '0;
    resp_pd    = '0;
  endtask

  task automatic check_no_pulse(input string tag);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_wr_cpl"}, 64'(wr_cpl), 64'd0);
  endtask

  task automatic check_pulse(input string tag);
    exp_t e;
    check({tag, "_sb_pending"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rd_valid"}, 64'(rd_valid), 64'(!e.wr));
      check({tag, "_wr_cpl"}, 64'(wr_cpl), 64'(e.wr));
      if (!e.wr) check({tag, "_data"}, 64'(rd_data), 64'(e.data));
    end
  endtask

  initial begin
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Reset state.
    check("rst_ready", 64'(csb_ready), 64'd1);
    check("rst_pvld", 64'(req_pvld), 64'd0);
    check("rst_pd", 64'(req_pd), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check_no_pulse("rst");
    check("rst_timeout", 64'(sched_timeout), 64'd0);

    // Read client 2, prdy immediate, response two cycles into WAIT.
    host_req(16'h2010, 32'h0, 1'b0, 1'b0);
    tick();
    csb_valid = 1'b0;
    check("rd2_pvld", 64'(req_pvld), 64'b0100);
    check("rd2_pd_lo", 64'(req_pd[21:0]), 64'h002010);
    check("rd2_pd", 64'(req_pd), 64'(mk_pd(16'h2010, 32'h0, 1'b0, 1'b0)));
    check("rd2_busy", 64'(csb_ready), 64'd0);
    req_prdy = 4'b0100;
    tick();
    req_prdy = '0;
    check("rd2_pvld_drop", 64'(req_pvld), 64'd0);
    check_no_pulse("rd2_wait0");
    tick();
    check_no_pulse("rd2_wait1");
    set_resp(2, 1'b0, 1'b0, 32'hCAFE_F00D);
    sb.push_back('{wr: 1'b0, data: 32'hCAFE_F00D});
    tick();
    clr_resp();
    check_pulse("rd2_done");
    check("rd2_done_busy", 64'(csb_ready), 64'd0);
    tick();
    check_no_pulse("rd2_after");
    check("rd2_ready", 64'(csb_ready), 64'd1);

    // Posted write client 0 with a 5-cycle prdy stall.
    host_req(16'h0004, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    csb_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("pw_stall_pvld", 64'(req_pvld), 64'b0001);
      check("pw_stall_pd", 64'(req_pd), 64'(mk_pd(16'h0004, 32'h1234_5678, 1'b1, 1'b0)));
      tick();
    end
    req_prdy = 4'b0001;
    check("pw_hs_pvld", 64'(req_pvld), 64'b0001);
    tick();
    req_prdy = '0;
    check("pw_ready", 64'(csb_ready), 64'd1);
    check("pw_pvld_drop", 64'(req_pvld), 64'd0);
    check_no_pulse("pw_h1");
    tick();
    check_no_pulse("pw_h2");

    // Non-posted write client 3: foreign client and wrong type are ignored.
    host_req(16'h3008, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    csb_valid = 1'b0;
    check("npw_pvld", 64'(req_pvld), 64'b1000);
    check("npw_pd", 64'(req_pd), 64'(mk_pd(16'h3008, 32'hDEAD_BEEF, 1'b1, 1'b1)));
    req_prdy = 4'b1000;
    tick();
    req_prdy = '0;
    set_resp(1, 1'b1, 1'b0, 32'h1111_1111);
    tick();
    check_no_pulse("npw_other_client");
    set_resp(3, 1'b0, 1'b0, 32'h3333_3333);
    tick();
    check_no_pulse("npw_wrong_type");
    set_resp(3, 1'b1, 1'b1, 32'h0);
    sb.push_back('{wr: 1'b1, data: 32'h0});
    tick();
    clr_resp();
    check_pulse("npw_done");
    tick();
    check_no_pulse("npw_after");
    check("npw_ready", 64'(csb_ready), 64'd1);

    // Unmapped read: pulse with data 0 at T+1, ready at T+2.
    host_req(16'hF000, 32'h0, 1'b0, 1'b0);
    sb.push_back('{wr: 1'b0, data: 32'h0});
    tick();
    csb_valid = 1'b0;
    check("um_pvld", 64'(req_pvld), 64'd0);
    check_pulse("um_done");
    check("um_busy", 64'(csb_ready), 64'd0);
    tick();
    check("um_ready", 64'(csb_ready), 64'd1);
    check_no_pulse("um_after");

`ifdef NVDLA_CSB_SCHED_TIMEOUT_EN
    // Silent client: timeout pulse 8 cycles after WAIT entry.
    host_req(16'h1000, 32'h0, 1'b0, 1'b0);
    tick();
    csb_valid = 1'b0;
    req_prdy = 4'b0010;
    tick();
    req_prdy = '0;
    for (int i = 0; i < 8; i++) begin
      check_no_pulse("to_wait");
      check("to_flag_low", 64'(sched_timeout), 64'd0);
      tick();
    end
    sb.push_back('{wr: 1'b0, data: 32'hFFFF_FFFF});
    check_pulse("to_done");
    check("to_flag", 64'(sched_timeout), 64'd1);
    tick();
    check("to_flag_sticky", 64'(sched_timeout), 64'd1);
`endif

    // Minimum-latency read: accept T, pulse T+3.
    host_req(16'h1040, 32'h0, 1'b0, 1'b0);
    tick();
    csb_valid = 1'b0;
    check("fast_pvld", 64'(req_pvld), 64'b0010);
    req_prdy = 4'b0010;
    tick();
    req_prdy = '0;
    set_resp(1, 1'b0, 1'b0, 32'hA5A5_0001);
    sb.push_back('{wr: 1'b0, data: 32'hA5A5_0001});
    tick();
    clr_resp();
    check_pulse("fast_done");
    tick();
    check("fast_ready", 64'(csb_ready), 64'd1);
`ifdef NVDLA_CSB_SCHED_TIMEOUT_EN
    check("fast_flag_sticky", 64'(sched_timeout), 64'd1);
`else
    check("no_wd_flag", 64'(sched_timeout), 64'd0);
`endif

    // Asynchronous reset while in REQ: pvld drops without a clock edge.
    host_req(16'h2000, 32'h0, 1'b0, 1'b0);
    tick();
    csb_valid = 1'b0;
    check("rreq_pvld", 64'(req_pvld), 64'b0100);
    #2 rstn = 1'b0;
    #1;
    check("rreq_pvld_async", 64'(req_pvld), 64'd0);
    check("rreq_pd_async", 64'(req_pd), 64'd0);
    check("rreq_ready", 64'(csb_ready), 64'd1);
    tick();
    rstn = 1'b1;
    tick();

    // Asynchronous reset while in WAIT; a late response must be dropped.
    host_req(16'h2000, 32'h0, 1'b0, 1'b0);
    tick();
    csb_valid = 1'b0;
    req_prdy = 4'b0100;
    tick();
    req_prdy = '0;
    check("rw_busy", 64'(csb_ready), 64'd0);
    #2 rstn = 1'b0;
    #1;
    check("rw_ready", 64'(csb_ready), 64'd1);
    check("rw_data", 64'(rd_data), 64'd0);
    check("rw_timeout", 64'(sched_timeout), 64'd0);
    check_no_pulse("rw_rst");
    tick();
    rstn = 1'b1;
    set_resp(2, 1'b0, 1'b0, 32'h5555_AAAA);
    tick();
    clr_resp();
    check_no_pulse("rw_late1");
    tick();
    check_no_pulse("rw_late2");
    check("rw_pvld", 64'(req_pvld), 64'd0);
    check("rw_ready_after", 64'(csb_ready), 64'd1);

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_csb_req_sched.md
# nv_nvdla_csb_req_sched

Single-outstanding CSB request scheduler between the host-side CSB port and a set of register-block clients, all on the core clock. It accepts one host request at a time and decodes the target client from the address. It drives that client's request channel, then waits for and routes back the client's read data or non-posted write completion. An optional watchdog bounds the response wait.

## Interface
Parameters:
- NUM_CLIENTS, 4: number of clients, 1..16.
- TIMEOUT_CYCLES, 1024: response wait limit in cycles, 2..65535. Used only with the watchdog.

Ports:
- Clock and reset: one clock, `nvdla_core_clk`; reset `nvdla_core_rstn` is asynchronous, active-low.
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  async active-low reset.
- csb2nvdla_valid  in  1  host request valid.
- csb2nvdla_ready  out  1  host request accept.
- csb2nvdla_addr  in  16  word address; [15:12] is the client index.
- csb2nvdla_wdat  in  32  write data.
- csb2nvdla_write  in  1  1=write, 0=read.
- csb2nvdla_nposted  in  1  write requires completion.
- nvdla2csb_valid  out  1  read-data pulse.
- nvdla2csb_data  out  32  read data.
- nvdla2csb_wr_complete  out  1  non-posted write completion pulse.
- req_pvld  out  NUM_CLIENTS  one-hot client request valid.
- req_prdy  in  NUM_CLIENTS  client request ready.
- req_pd  out  63  shared request payload.
- resp_valid  in  NUM_CLIENTS  client response valid.
- resp_pd  in  34*NUM_CLIENTS  client i occupies [34*i+33:34*i].
- sched_timeout  out  1  sticky watchdog flag.

## Operation
- Request payload layout:
  - req_pd[21:0] = {6'b0, addr}.
  - [53:22] = wdat.
  - [54] = write.
  - [55] = nposted.
  - [62:56] = 0.
- Response payload layout: resp_pd[31:0] = data; [32] = error, ignored; [33] = type, 0=read, 1=write.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - csb2nvdla_ready=1.
  - On valid&ready, register the request and client index = addr[15:12].
  - If index < NUM_CLIENTS, go to REQ.
  - Otherwise (unmapped), go to DONE with data 0. A read returns a valid pulse; a non-posted write returns a wr_complete pulse; a posted write returns nothing.
- REQ:
  - req_pvld[idx]=1, req_pd stable.
  - On req_prdy[idx]=1: a posted write goes to IDLE; a read or non-posted write goes to WAIT.
- WAIT:
  - Wait for resp_valid[idx] with a type bit that matches the transaction (read→0, write→1), then go to DONE with the captured data.
  - Ignore resp_valid from other clients, and mismatched types.
- DONE:
  - Read: one-cycle nvdla2csb_valid with nvdla2csb_data.
  - Non-posted write: one-cycle nvdla2csb_wr_complete.
  - Then go to IDLE.
- Responses arriving while in IDLE, REQ or DONE are dropped.

## Timing
- Reset values:
  - State IDLE.
  - All req_pvld=0, req_pd=0.
  - nvdla2csb_valid=0, nvdla2csb_data=0, nvdla2csb_wr_complete=0.
  - sched_timeout=0.
  - csb2nvdla_ready=1 one cycle after reset deassertion. It is combinational from state, so 1 in IDLE.
- All outputs except csb2nvdla_ready are registered.
- Host accept at cycle T:
  - req_pvld rises at T+1.
  - Client handshake at cycle H → WAIT from H+1.
  - Response at cycle R → pulse at R+1 → ready again at R+2.
- Minimum read latency, accept to data, is 3 cycles when prdy and the response each arrive at their first possible cycle.
- Posted write: ready again at H+1.
- Unmapped access: pulse at T+1, ready at T+2.
- Reset mid-transaction aborts immediately: req_pvld drops asynchronously; no pulse is issued.

## Configuration
- NVDLA_CSB_SCHED_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without a matching response, go to DONE with data 32'hFFFF_FFFF. A read gets a valid pulse; a non-posted write gets wr_complete.
  - sched_timeout sets and holds until reset.
  - A matching response in the same cycle as expiry wins; no timeout is flagged.
- Not defined: no counter; WAIT is unbounded; sched_timeout is tied 0.

## Test plan
- Read client 2, addr 16'h2010: prdy immediate, response {type 0, data 32'hCAFE_F00D} two cycles later → req_pd[21:0]=22'h002010, nvdla2csb_data=32'hCAFE_F00D for one cycle, no wr_complete.
- Posted write client 0, wdat 32'h1234_5678: prdy held low 5 cycles → req_pvld[0] and req_pd stable through the stall; ready returns one cycle after the handshake; no response pulse.
- Non-posted write client 3: client 1 sends a response and client 3 sends a type-0 response first, then client 3 sends a type-1 response → only the last produces a single wr_complete pulse.
- Read of unmapped addr 16'hF000 with NUM_CLIENTS=4 → no req_pvld, nvdla2csb_valid with data 0 at T+1.
- With the macro defined and TIMEOUT_CYCLES=8, a read to a silent client → data 32'hFFFF_FFFF pulse 8 cycles after WAIT entry, sched_timeout=1 and stays set; the next read completes normally.
- Assert reset while in WAIT → all outputs return to reset values asynchronously; a late response after reset produces no pulse.
